mem_copy_engine: RTL

Memory-side initiator that copies a block of 32-bit words from one byte address to another over the byte-addressed, little-endian unified memory port of the multi-cycle MIPS. It drives the same address, write-data, read-enable and write-enable signals the processor datapath drives. It samples the memory's combinational read data. Control logic (or a testbench) starts it to move data-segment blocks without processor involvement; the memory port must not be driven by anyone else while `busy` is high.

---
 rtl/mem_copy_engine_if.sv | 29 ++
 rtl/mem_copy_engine.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_copy_engine_if.sv
// Control and memory-port bundle for mem_copy_engine.
// The master modport is the engine side; the slave modport is the
// controller/memory side that starts transfers and serves read data.
interface mem_copy_engine_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [31:0]      src_adr;
    logic [31:0]      dst_adr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      adr;
    logic [31:0]      d_in;
    logic             mrd;
    logic             mwr;
    logic [31:0]      d_out;

    modport master (
        input  start, src_adr, dst_adr, len, d_out,
        output busy, done, err, adr, d_in, mrd, mwr
    );

    modport slave (
        output start, src_adr, dst_adr, len, d_out,
        input  busy, done, err, adr, d_in, mrd, mwr
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word block copier for the unified MIPS memory port.
// Each word takes one READ cycle (data captured into a holding register)
// followed by one WRITE cycle, so throughput is 2 cycles per word.
// Outputs decode only from registered state, so the memory sees clean
// Moore-style control with no combinational path from start/len.
module mem_copy_engine #(
    parameter int LEN_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_copy_engine_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if ((bus.src_adr[1:0] != 2'b00) || (bus.dst_adr[1:0] != 2'b00)) begin
                        state_d = S_ERR;
                    end else if (bus.len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        src_ptr_d = bus.src_adr;
                        dst_ptr_d = bus.dst_adr;
                        cnt_d     = bus.len;
                        state_d   = S_READ;
                    end
                end
            end
            S_READ: begin
                word_d    = bus.d_out;
                src_ptr_d = src_ptr_q + 32'd4;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                dst_ptr_d = dst_ptr_q + 32'd4;
                cnt_d     = cnt_q - CNT_ONE;
                state_d   = (cnt_q == CNT_ONE) ? S_DONE : S_READ;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state; the bus is quiet outside READ/WRITE.
    always_comb begin
        bus.busy = (state_q != S_IDLE);
        bus.done = (state_q == S_DONE);
        bus.err  = (state_q == S_ERR);
        bus.adr  = 32'h0;
        bus.d_in = 32'h0;
        bus.mrd  = 1'b0;
        bus.mwr  = 1'b0;
        case (state_q)
            S_READ: begin
                bus.mrd = 1'b1;
                bus.adr = src_ptr_q;
            end
            S_WRITE: begin
                bus.mwr  = 1'b1;
                bus.adr  = dst_ptr_q;
                bus.d_in = word_q;
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset aborts any transfer on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            src_ptr_q <= 32'h0;
            dst_ptr_q <= 32'h0;
            cnt_q     <= '0;
            word_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
        end
    end
endmodule
